// File: rtl/ysyx_22050854_mem_arbiter.sv
// Shares one 64-bit memory port between IFU and LSU, one transaction at a time.
// Define ARB_RR_EN for round-robin grant on ties (default: LSU over IFU).
module ysyx_22050854_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_resp_valid,
    output logic [31:0]           ifu_resp_data,
    input  logic                  lsu_req_valid,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [2:0]            lsu_req_op,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    output logic                  lsu_req_ready,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e              state_q;
    logic                owner_q;   // 1 = LSU
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [2:0]          op_q;
    logic [2:0]          off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       wmask_q;
    logic                ifu_rv_q, lsu_rv_q;
    logic [31:0]         ifu_rd_q;
    logic [DATA_W-1:0]   lsu_rd_q;

    logic                grant_lsu, idle, hs;
    logic [2:0]          lsu_off;
    logic [NB-1:0]       lsu_mask;
    logic [DATA_W-1:0]   raw, ld_ext;

`ifdef ARB_RR_EN
    logic last_lsu_q;
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
`else
    assign grant_lsu = lsu_req_valid;
`endif

    // Ready is masked during reset so no handshake can slip through it.
    assign idle          = (state_q == S_IDLE) && !rst;
    assign lsu_req_ready = idle && grant_lsu;
    assign ifu_req_ready = idle && !grant_lsu && ifu_req_valid;
    assign hs            = lsu_req_ready || ifu_req_ready;

    assign lsu_off = lsu_req_addr[2:0];

    always_comb begin
        case (lsu_req_op[1:0])
            2'b00:   lsu_mask = {{(NB-1){1'b0}}, 1'b1} << lsu_off;
            2'b01:   lsu_mask = {{(NB-2){1'b0}}, 2'b11} << lsu_off;
            2'b10:   lsu_mask = {{(NB-4){1'b0}}, 4'hF} << lsu_off;
            default: lsu_mask = '1;
        endcase
    end

    assign raw = mem_resp_data >> {off_q, 3'b000};

    always_comb begin
        case (op_q)
            3'b000:  ld_ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            3'b001:  ld_ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            3'b010:  ld_ext = {{(DATA_W-32){raw[31]}}, raw[31:0]};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
            3'b110:  ld_ext = {{(DATA_W-32){1'b0}}, raw[31:0]};
            default: ld_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            op_q     <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            ifu_rv_q <= 1'b0;
            lsu_rv_q <= 1'b0;
            ifu_rd_q <= '0;
            lsu_rd_q <= '0;
`ifdef ARB_RR_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            ifu_rv_q <= 1'b0;
            lsu_rv_q <= 1'b0;
            case (state_q)
                S_IDLE: if (hs) begin
                    state_q <= S_REQ;
                    owner_q <= grant_lsu;
`ifdef ARB_RR_EN
                    last_lsu_q <= grant_lsu;
`endif
                    if (grant_lsu) begin
                        addr_q  <= {lsu_req_addr[ADDR_W-1:3], 3'b000};
                        wen_q   <= lsu_req_wen;
                        op_q    <= lsu_req_op;
                        off_q   <= lsu_off;
                        wdata_q <= lsu_req_wdata << {lsu_off, 3'b000};
                        wmask_q <= lsu_req_wen ? lsu_mask : '0;
                    end else begin
                        addr_q  <= {ifu_req_addr[ADDR_W-1:3], 3'b000};
                        wen_q   <= 1'b0;
                        op_q    <= 3'b011;
                        off_q   <= ifu_req_addr[2:0];
                        wdata_q <= '0;
                        wmask_q <= '0;
                    end
                end
                S_REQ: if (mem_req_ready) state_q <= S_RESP;
                S_RESP: if (mem_resp_valid) begin
                    state_q <= S_IDLE;
                    if (owner_q) begin
                        lsu_rv_q <= 1'b1;
                        lsu_rd_q <= wen_q ? '0 : ld_ext;
                    end else begin
                        ifu_rv_q <= 1'b1;
                        ifu_rd_q <= off_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_valid = ifu_rv_q;
    assign ifu_resp_data  = ifu_rd_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign lsu_resp_data  = lsu_rd_q;

endmodule

// File: doc/ysyx_22050854_mem_arbiter.md
Name: ysyx_22050854_mem_arbiter

Overview:
Shares the core's single 64-bit memory port between the instruction fetch unit (IFU) and the load/store unit (LSU), one transaction at a time.
The LSU side is driven by the decoder's MemWr/MemOP controls. The block generates the byte write mask from MemOP and the address, and returns extracted load data to the LSU and a 32-bit instruction word to the IFU.
It sits between the IFU/LSU and the memory/bus interface.

Parameters:
ADDR_W, 64, address width of all request ports
DATA_W, 64, memory data width (fixed 64; wmask is DATA_W/8 bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  fetch request
ifu_req_addr  in  ADDR_W  fetch address, 4-byte aligned
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_resp_valid  out  1  one-cycle pulse, instruction returned
ifu_resp_data  out  32  instruction word
lsu_req_valid  in  1  load/store request
lsu_req_addr  in  ADDR_W  byte address, naturally aligned to access size
lsu_req_wen  in  1  1 = store (MemWr)
lsu_req_op  in  3  MemOP: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
lsu_req_wdata  in  64  store data, right-justified
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_resp_valid  out  1  one-cycle pulse, load data or store ack
lsu_resp_data  out  64  extended load data; 0 for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request address with [2:0] forced to 0
mem_req_wen  out  1  write enable
mem_req_wdata  out  64  store data shifted to byte lane
mem_req_wmask  out  8  byte enables, 0 for reads
mem_resp_valid  in  1  read data / write ack, one per request
mem_resp_data  in  64  raw 8-byte-aligned read data

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; owner register = IFU; response data registers = 0.
- Handshakes:
  - Requesters hold valid and payload stable until ready.
  - A transfer occurs when valid and ready are both high.
  - ready is combinational, asserted only in IDLE and only to the granted requester.
- States:
  - IDLE:
    - Grant: LSU if lsu_req_valid, else IFU if ifu_req_valid.
    - On the handshake, latch owner, aligned addr, wen, op, addr[2:0], lane-shifted wdata and wmask, then go to REQ.
  - REQ:
    - mem_req_valid = 1, driven from registers only.
    - On mem_req_ready, go to RESP. Stay in REQ indefinitely otherwise.
  - RESP:
    - Wait for mem_resp_valid, then go to IDLE.
    - Next cycle: the owner's resp_valid = 1 for exactly one cycle with registered data.
    - A new request may be accepted in that same IDLE cycle.
- Latency:
  - Accept at cycle N; mem_req_valid at N+1.
  - If mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid at N+3.
  - At most one transaction outstanding.
- IFU read: wen = 0, wmask = 0. ifu_resp_data = addr[2] ? data[63:32] : data[31:0].
- Write mask, with a = addr[2:0]:
  - op[1:0] = 00: 8'h01 << a
  - op[1:0] = 01: 8'h03 << a
  - op[1:0] = 10: 8'h0F << a
  - op[1:0] = 11: 8'hFF
  - mem_req_wdata = wdata << (8*a).
- Load extract: raw = mem_resp_data >> (8*a).
  - op 000/001/010: sign-extend the low 8/16/32 bits.
  - op 100/101/110: zero-extend the low 8/16/32 bits.
  - op 011: full 64 bits.
  - op 111: treated as 011.
- Store: lsu_resp_valid is the write ack; lsu_resp_data = 0.
- mem_resp_valid outside RESP is ignored, with no state or output change.
- Both requesters valid in the same IDLE cycle: only the granted one sees ready; the other holds its request.
- rst in any state: immediately IDLE, outputs 0, in-flight transaction dropped, no resp pulse generated. A late mem_resp_valid after reset is ignored.

Optional Feature:
ARB_RR_EN:
- Defined: on simultaneous valid requests in IDLE, grant the requester not granted last. The last-grant register resets to IFU, so the first tie goes to LSU. A single valid requester is always granted.
- Undefined: fixed priority, LSU over IFU.

Test Plan:
- IFU fetch, addr 0x8000_0004, mem returns 0x1111_2222_3333_4444 → ifu_resp_data = 0x1111_2222, mem_req_addr = 0x8000_0000, wmask = 0, resp at N+3.
- LSU sb, addr 0x8000_0013, wdata 0xAB → mem_req_addr 0x8000_0010, wmask 8'h08, wdata 0xAB00_0000; ack pulse with lsu_resp_data 0.
- LSU lh / lhu at addr offset 6, mem data 0x8001_0000_0000_0000 → 0xFFFF_FFFF_FFFF_8001 / 0x0000_0000_0000_8001.
- IFU and LSU valid together in IDLE → LSU granted first, IFU granted the next time IDLE is reached. With ARB_RR_EN and both held continuously, grants alternate LSU, IFU, LSU.
- mem_req_ready held low 5 cycles → mem_req_valid and payload stable for all 5 cycles, both ready outputs 0, no resp.
- rst pulsed while in RESP, then mem_resp_valid arrives → no resp_valid pulse, state IDLE, next request serviced normally.
